riscv_rf_wbarb: RTL
===================

RISCV_RF_WBARB -- requirements
Module: riscv_rf_wbarb

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive stalled cycles of requester 1 before it is forced to win (legal range 1..15).
REQ-002 i_riscv_wbarb_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_riscv_wbarb_rst  in  1  reset, synchronous, active-high.
REQ-004 i_riscv_wbarb_p0_valid  in  1  pipeline writeback request valid.
REQ-005 i_riscv_wbarb_p0_rd  in  5  pipeline destination register.
REQ-006 i_riscv_wbarb_p0_data  in  64  pipeline writeback data.
REQ-007 o_riscv_wbarb_p0_ready  out  1  pipeline request accepted this cycle.
REQ-008 i_riscv_wbarb_p1_valid  in  1  long-latency unit (mul/div) writeback valid.
REQ-009 i_riscv_wbarb_p1_rd  in  5  long-latency destination register.
REQ-010 i_riscv_wbarb_p1_data  in  64  long-latency writeback data.
REQ-011 o_riscv_wbarb_p1_ready  out  1  long-latency request accepted this cycle.
REQ-012 i_riscv_wbarb_issue_valid  in  1  long-latency op issued; marks rd pending.
REQ-013 i_riscv_wbarb_issue_rd  in  5  destination of issued long-latency op.
REQ-014 o_riscv_wbarb_regwrite  out  1  register-file write enable.
REQ-015 o_riscv_wbarb_rdaddr  out  5  register-file write address.
REQ-016 o_riscv_wbarb_rddata  out  64  register-file write data.
REQ-017 o_riscv_wbarb_busy  out  32  per-register pending-write bitmap; bit 0 always 0.

Function
REQ-018 Handshake: transfer on requester k when pk_valid and pk_ready both high at a rising edge; ready is combinational from valid and arbiter state.
REQ-019 At most one of p0_ready, p1_ready high per cycle; ready low whenever its valid is low.
REQ-020 FSM states PRI0 and FORCE1; in PRI0, p0 wins if valid, else p1 wins if valid.
REQ-021 Starve counter (4 bits) increments each cycle p1_valid=1 and p1_ready=0; clears to 0 on any p1 transfer or when p1_valid=0.
REQ-022 PRI0 -> FORCE1 when counter reaches STARVE_LIMIT; in FORCE1 p1 wins regardless of p0; FORCE1 -> PRI0 after the p1 transfer, or if p1_valid drops.
REQ-023 Winner's rd/data registered; regwrite/rdaddr/rddata valid the cycle after transfer (1-cycle latency), for exactly one cycle per transfer.
REQ-024 Transfer with rd=0: accepted (ready high) but regwrite stays 0 next cycle.
REQ-025 No transfer in a cycle: regwrite=0 next cycle; rdaddr/rddata hold previous values.
REQ-026 Busy: issue_valid with issue_rd!=0 sets busy[issue_rd] at next edge; p1 transfer clears busy[p1_rd]; issue to x0 ignored.
REQ-027 Simultaneous set and clear of same bit: set wins (bit stays 1).
REQ-028 p0 transfers never modify busy.
REQ-029 Back-to-back transfers allowed every cycle; throughput one write per cycle.

Reset
REQ-030 While rst high at an edge: regwrite=0, rdaddr=0, rddata=0, busy=0, counter=0, state=PRI0.
REQ-031 During a reset cycle both ready outputs are 0; in-flight requests are dropped, and requesters re-present them after reset.
REQ-032 Reset asserted mid-FORCE1 returns to PRI0 with counter 0 on the next edge.

Structure
REQ-033 FSM state encodings, XLEN=64 and register-index width 5 are defined in shared package riscv_pkg.
REQ-034 The busy bitmap is a sub-module riscv_rf_scoreboard (set/clear ports, 32-bit output); the arbiter FSM, counter and output registers stay in riscv_rf_wbarb.

Verification
REQ-035 p0 only: p0_valid, rd=5, data=0xA5 -> p0_ready=1 same cycle; next cycle regwrite=1, rdaddr=5, rddata=0xA5.
REQ-036 Contention, STARVE_LIMIT=4: p0 and p1 valid continuously -> p0 wins 4 cycles, p1 wins 5th cycle, p0 wins 6th.
REQ-037 x0 write: p1 rd=0, data=0xFFFF -> p1_ready=1, regwrite=0 next cycle, busy unchanged.
REQ-038 Scoreboard: issue rd=7, then p1 rd=7 transfer 3 cycles later -> busy[7]=1 for those cycles, 0 after; issue rd=9 and p1 rd=9 transfer same cycle -> busy[9]=1.
REQ-039 Reset mid-operation: enter FORCE1, busy=0x0000_0080, assert rst one cycle -> readies 0, busy=0, regwrite=0, next arbitration favours p0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and the writeback arbiter state encoding.
package riscv_pkg;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    typedef enum logic {
        ST_PRI0   = 1'b0,
        ST_FORCE1 = 1'b1
    } wbarb_state_e;
endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Per-register pending-write bitmap: set on long-latency issue, cleared on its writeback.
// Set beats clear on the same register; x0 is never marked pending.
module riscv_rf_scoreboard
    import riscv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_vld_i,
    input  logic [REG_AW-1:0] set_rd_i,
    input  logic              clr_vld_i,
    input  logic [REG_AW-1:0] clr_rd_i,
    output logic [NREGS-1:0]  busy_o
);
    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] set_mask, clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_vld_i) set_mask[set_rd_i] = 1'b1;
        if (clr_vld_i) clr_mask[clr_rd_i] = 1'b1;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/riscv_rf_wbarb.sv
// Two-port register-file writeback arbiter: pipeline (p0) has priority, long-latency unit (p1)
// is forced through after STARVE_LIMIT stalled cycles. Ready is combinational; write port is 1 cycle later.
module riscv_rf_wbarb
    import riscv_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_riscv_wbarb_clk,
    input  logic              i_riscv_wbarb_rst,
    input  logic              i_riscv_wbarb_p0_valid,
    input  logic [REG_AW-1:0] i_riscv_wbarb_p0_rd,
    input  logic [XLEN-1:0]   i_riscv_wbarb_p0_data,
    output logic              o_riscv_wbarb_p0_ready,
    input  logic              i_riscv_wbarb_p1_valid,
    input  logic [REG_AW-1:0] i_riscv_wbarb_p1_rd,
    input  logic [XLEN-1:0]   i_riscv_wbarb_p1_data,
    output logic              o_riscv_wbarb_p1_ready,
    input  logic              i_riscv_wbarb_issue_valid,
    input  logic [REG_AW-1:0] i_riscv_wbarb_issue_rd,
    output logic              o_riscv_wbarb_regwrite,
    output logic [REG_AW-1:0] o_riscv_wbarb_rdaddr,
    output logic [XLEN-1:0]   o_riscv_wbarb_rddata,
    output logic [NREGS-1:0]  o_riscv_wbarb_busy
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    wbarb_state_e      state_q;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [REG_AW-1:0] addr_q;
    logic [XLEN-1:0]   data_q;

    logic              p0_rdy, p1_rdy, any_xfer;
    logic [REG_AW-1:0] win_rd;
    logic [XLEN-1:0]   win_data;

    // In FORCE1 with p1 idle, p0 still takes the slot rather than wasting the cycle.
    always_comb begin
        p1_rdy = !i_riscv_wbarb_rst && i_riscv_wbarb_p1_valid &&
                 ((state_q == ST_FORCE1) || !i_riscv_wbarb_p0_valid);
        p0_rdy = !i_riscv_wbarb_rst && i_riscv_wbarb_p0_valid && !p1_rdy;
        any_xfer = p0_rdy || p1_rdy;
        win_rd   = p1_rdy ? i_riscv_wbarb_p1_rd   : i_riscv_wbarb_p0_rd;
        win_data = p1_rdy ? i_riscv_wbarb_p1_data : i_riscv_wbarb_p0_data;
    end

    always_comb begin
        cnt_d = '0;
        if (i_riscv_wbarb_p1_valid && !p1_rdy)
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    end

    always_ff @(posedge i_riscv_wbarb_clk) begin
        if (i_riscv_wbarb_rst) begin
            state_q <= ST_PRI0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                ST_PRI0:   if (cnt_d >= LIMIT) state_q <= ST_FORCE1;
                ST_FORCE1: if (p1_rdy || !i_riscv_wbarb_p1_valid) state_q <= ST_PRI0;
                default:   state_q <= ST_PRI0;
            endcase
            wr_q <= any_xfer && (win_rd != '0);
            if (any_xfer) begin
                addr_q <= win_rd;
                data_q <= win_data;
            end
        end
    end

    riscv_rf_scoreboard u_scoreboard (
        .clk_i     (i_riscv_wbarb_clk),
        .rst_i     (i_riscv_wbarb_rst),
        .set_vld_i (i_riscv_wbarb_issue_valid),
        .set_rd_i  (i_riscv_wbarb_issue_rd),
        .clr_vld_i (p1_rdy),
        .clr_rd_i  (i_riscv_wbarb_p1_rd),
        .busy_o    (o_riscv_wbarb_busy)
    );

    assign o_riscv_wbarb_p0_ready = p0_rdy;
    assign o_riscv_wbarb_p1_ready = p1_rdy;
    assign o_riscv_wbarb_regwrite = wr_q;
    assign o_riscv_wbarb_rdaddr   = addr_q;
    assign o_riscv_wbarb_rddata   = data_q;
endmodule
